// File: rtl/mips64_hazard_ctrl_pkg.sv
// mips64_pipe_pkg: shared constants for the MIPS64 pipeline control slice.
//   STG_*   : bit positions of the pipeline registers in stall/flush vectors
//   FWD_*   : IE operand-select encodings
//   cause_e : the winning stall/flush cause, ranked for debug visibility
package mips64_pipe_pkg;

  localparam logic [1:0] STG_IF_ID  = 2'd0;
  localparam logic [1:0] STG_ID_IE  = 2'd1;
  localparam logic [1:0] STG_IE_MEM = 2'd2;
  localparam logic [1:0] STG_MEM_WB = 2'd3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    CAUSE_RUN,
    CAUSE_IWAIT,
    CAUSE_LOAD_USE,
    CAUSE_BRANCH,
    CAUSE_EXC,
    CAUSE_DWAIT
  } cause_e;

endpackage

// File: rtl/mips64_hazard_ctrl_if.sv
// mips64_hazard_ctrl_if: bundle between the 5-stage core (master) and the
// hazard controller (slave).
//   core -> ctrl : ID/IE source regs and use flags, per-stage dest/write/load,
//                  memory waits, taken branch, exception pulse
//   ctrl -> core : PC hold, per-register stall/flush, IE forward selects,
//                  stall-cycle and flush-event counters
interface mips64_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic [REG_AW-1:0] p_ID_RS, p_ID_RT;
  logic              p_ID_UsesRS, p_ID_UsesRT;
  logic [REG_AW-1:0] p_IE_RS, p_IE_RT;
  logic [REG_AW-1:0] p_IE_RegDest, p_MEM_RegDest, p_WB_RegDest;
  logic              p_IE_RegWrite, p_MEM_RegWrite, p_WB_RegWrite;
  logic              p_IE_MemRead, p_MEM_MemRead;
  logic              p_INST_MemWait, p_DATA_MemWait;
  logic              p_BranchTaken;
  logic              p_Exception;

  logic              p_PC_Stall;
  logic [3:0]        p_Stall;
  logic [3:0]        p_Flush;
  logic [1:0]        p_FwdA, p_FwdB;
  logic [CNT_W-1:0]  p_StallCycles, p_FlushEvents;

  modport master (
    output p_ID_RS, p_ID_RT, p_ID_UsesRS, p_ID_UsesRT, p_IE_RS, p_IE_RT,
           p_IE_RegDest, p_MEM_RegDest, p_WB_RegDest,
           p_IE_RegWrite, p_MEM_RegWrite, p_WB_RegWrite,
           p_IE_MemRead, p_MEM_MemRead, p_INST_MemWait, p_DATA_MemWait,
           p_BranchTaken, p_Exception,
    input  p_PC_Stall, p_Stall, p_Flush, p_FwdA, p_FwdB,
           p_StallCycles, p_FlushEvents
  );

  modport slave (
    input  p_ID_RS, p_ID_RT, p_ID_UsesRS, p_ID_UsesRT, p_IE_RS, p_IE_RT,
           p_IE_RegDest, p_MEM_RegDest, p_WB_RegDest,
           p_IE_RegWrite, p_MEM_RegWrite, p_WB_RegWrite,
           p_IE_MemRead, p_MEM_MemRead, p_INST_MemWait, p_DATA_MemWait,
           p_BranchTaken, p_Exception,
    output p_PC_Stall, p_Stall, p_Flush, p_FwdA, p_FwdB,
           p_StallCycles, p_FlushEvents
  );

endinterface

// File: rtl/mips64_fwd_sel.sv
// mips64_fwd_sel: operand forward select for one IE source register.
//   src          : IE source register
//   mem_rd/we    : MEM destination and write enable; mem_load blocks MEM
//                  forwarding since the load data is not yet available
//   wb_rd/we     : WB destination and write enable
//   sel          : FWD_MEM, FWD_WB or FWD_RF (MEM wins over WB)
module mips64_fwd_sel
  import mips64_pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic              mem_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (mem_we && !mem_load && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/mips64_hazard_ctrl.sv
// mips64_hazard_ctrl: stall/flush/forward controller for the 5-stage MIPS64.
//   p_clk   : core clock, rising edge
//   p_rst_l : asynchronous active-low reset; forces all four flushes
//   bus     : slave side of mips64_hazard_ctrl_if (hazard inputs in,
//             PC hold / stall / flush / forward selects / counters out)
// Priority: data wait > exception (new or pending) > taken branch >
// load-use (new or extra bubble) > instruction wait > run.
module mips64_hazard_ctrl
  import mips64_pipe_pkg::*;
#(
  parameter int unsigned REG_AW             = 5,
  parameter int unsigned CNT_W              = 32,
  parameter int unsigned LOAD_USE_BUBBLES   = 1,
  parameter int unsigned BRANCH_FLUSH_DEPTH = 3
) (
  input logic                p_clk,
  input logic                p_rst_l,
  mips64_hazard_ctrl_if.slave bus
);

  // Extra bubble cycles beyond the detection cycle fit in one bit (max 1).
  localparam logic       BUB_LOAD = (LOAD_USE_BUBBLES > 32'd1);
  localparam logic [3:0] BR_MASK  = 4'((32'd1 << BRANCH_FLUSH_DEPTH) - 32'd1);

  logic             bub_q, bub_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  cause_e     cause;
  logic       lu_hit;
  logic       pc_stall;
  logic [3:0] stall, flush;
  logic [1:0] fwd_a, fwd_b;

  mips64_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src(bus.p_IE_RS), .mem_rd(bus.p_MEM_RegDest), .mem_we(bus.p_MEM_RegWrite),
    .mem_load(bus.p_MEM_MemRead), .wb_rd(bus.p_WB_RegDest),
    .wb_we(bus.p_WB_RegWrite), .sel(fwd_a)
  );

  mips64_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src(bus.p_IE_RT), .mem_rd(bus.p_MEM_RegDest), .mem_we(bus.p_MEM_RegWrite),
    .mem_load(bus.p_MEM_MemRead), .wb_rd(bus.p_WB_RegDest),
    .wb_we(bus.p_WB_RegWrite), .sel(fwd_b)
  );

  always_comb begin
    lu_hit = bus.p_IE_MemRead && bus.p_IE_RegWrite && (bus.p_IE_RegDest != '0) &&
             ((bus.p_ID_UsesRS && (bus.p_ID_RS == bus.p_IE_RegDest)) ||
              (bus.p_ID_UsesRT && (bus.p_ID_RT == bus.p_IE_RegDest)));
  end

  always_comb begin
    if (bus.p_DATA_MemWait)                   cause = CAUSE_DWAIT;
    else if (bus.p_Exception || pend_q)       cause = CAUSE_EXC;
    else if (bus.p_BranchTaken)               cause = CAUSE_BRANCH;
    else if (lu_hit || bub_q)                 cause = CAUSE_LOAD_USE;
    else if (bus.p_INST_MemWait)              cause = CAUSE_IWAIT;
    else                                      cause = CAUSE_RUN;
  end

  // State register
  always_ff @(posedge p_clk or negedge p_rst_l) begin
    if (!p_rst_l) begin
      bub_q       <= 1'b0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      bub_q       <= bub_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state: data wait freezes the bubble and parks any exception.
  always_comb begin
    bub_d  = bub_q;
    pend_d = pend_q;
    unique case (cause)
      CAUSE_DWAIT:    if (bus.p_Exception) pend_d = 1'b1;
      CAUSE_EXC: begin
        bub_d  = 1'b0;
        pend_d = 1'b0;
      end
      CAUSE_BRANCH:   bub_d = 1'b0;
      CAUSE_LOAD_USE: bub_d = bub_q ? 1'b0 : BUB_LOAD;
      default:        bub_d = 1'b0;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);

    flush_cnt_d = flush_cnt_q;
    if (((cause == CAUSE_EXC) || (cause == CAUSE_BRANCH)) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    pc_stall = 1'b0;
    stall    = '0;
    flush    = '0;
    if (!p_rst_l) begin
      flush = '1;
    end else begin
      unique case (cause)
        CAUSE_DWAIT: begin
          pc_stall = 1'b1;
          stall    = '1;
        end
        CAUSE_EXC: begin
          flush[STG_IF_ID]  = 1'b1;
          flush[STG_ID_IE]  = 1'b1;
          flush[STG_IE_MEM] = 1'b1;
        end
        CAUSE_BRANCH: flush = BR_MASK;
        CAUSE_LOAD_USE: begin
          pc_stall         = 1'b1;
          stall[STG_IF_ID] = 1'b1;
          flush[STG_ID_IE] = 1'b1;
        end
        CAUSE_IWAIT: begin
          pc_stall         = 1'b1;
          flush[STG_IF_ID] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.p_PC_Stall    = pc_stall;
  assign bus.p_Stall       = stall;
  assign bus.p_Flush       = flush;
  assign bus.p_FwdA        = p_rst_l ? fwd_a : FWD_RF;
  assign bus.p_FwdB        = p_rst_l ? fwd_b : FWD_RF;
  assign bus.p_StallCycles = stall_cnt_q;
  assign bus.p_FlushEvents = flush_cnt_q;

endmodule

// File: tb/tb_mips64_hazard_ctrl.sv
// Bench for mips64_hazard_ctrl: two instances (1 bubble / depth 3 and
// 2 bubbles / depth 2) driven identically and compared against a
// rule-level model, plus a constant-expectation table and corner sequences.
module tb_mips64_hazard_ctrl;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  mips64_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus0 ();
  mips64_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus1 ();

  mips64_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .LOAD_USE_BUBBLES(1), .BRANCH_FLUSH_DEPTH(3))
    dut0 (.p_clk(clk), .p_rst_l(rst_l), .bus(bus0.slave));
  mips64_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .LOAD_USE_BUBBLES(2), .BRANCH_FLUSH_DEPTH(2))
    dut1 (.p_clk(clk), .p_rst_l(rst_l), .bus(bus1.slave));

  typedef struct {
    logic [4:0] id_rs, id_rt, ie_rs, ie_rt, ie_rd, mem_rd, wb_rd;
    logic uses_rs, uses_rt, ie_we, ie_load, mem_we, mem_load, wb_we;
    logic iwait, dwait, br, exc;
  } in_t;

  typedef struct {
    logic       pc_stall;
    logic [3:0] stall, flush;
    logic [1:0] fwd_a, fwd_b;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  int lub[2] = '{1, 2};
  int bfd[2] = '{3, 2};
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  // Model state: remaining forced bubble cycles, pending exception, counters.
  int              m_bub[2];
  bit              m_pend[2];
  longint unsigned m_sc[2], m_fc[2];

  function automatic in_t idle_in();
    in_t v;
    v.id_rs = 0; v.id_rt = 0; v.ie_rs = 0; v.ie_rt = 0; v.ie_rd = 0;
    v.mem_rd = 0; v.wb_rd = 0; v.uses_rs = 0; v.uses_rt = 0; v.ie_we = 0;
    v.ie_load = 0; v.mem_we = 0; v.mem_load = 0; v.wb_we = 0;
    v.iwait = 0; v.dwait = 0; v.br = 0; v.exc = 0;
    return v;
  endfunction

  function automatic in_t lu_in();
    in_t v = idle_in();
    v.ie_load = 1; v.ie_we = 1; v.ie_rd = 5; v.uses_rs = 1; v.id_rs = 5;
    return v;
  endfunction

  function automatic out_t mk_out(logic pc, logic [3:0] st, logic [3:0] fl, logic [1:0] fa, logic [1:0] fb);
    out_t o;
    o.pc_stall = pc; o.stall = st; o.flush = fl; o.fwd_a = fa; o.fwd_b = fb;
    return o;
  endfunction

  function automatic vec_t mk(string n, in_t v, out_t o);
    vec_t t;
    t.name = n; t.i = v; t.o = o;
    return t;
  endfunction

  task automatic drive(input in_t v);
    bus0.p_ID_RS = v.id_rs; bus0.p_ID_RT = v.id_rt; bus0.p_ID_UsesRS = v.uses_rs; bus0.p_ID_UsesRT = v.uses_rt;
    bus0.p_IE_RS = v.ie_rs; bus0.p_IE_RT = v.ie_rt; bus0.p_IE_RegDest = v.ie_rd;
    bus0.p_MEM_RegDest = v.mem_rd; bus0.p_WB_RegDest = v.wb_rd;
    bus0.p_IE_RegWrite = v.ie_we; bus0.p_MEM_RegWrite = v.mem_we; bus0.p_WB_RegWrite = v.wb_we;
    bus0.p_IE_MemRead = v.ie_load; bus0.p_MEM_MemRead = v.mem_load;
    bus0.p_INST_MemWait = v.iwait; bus0.p_DATA_MemWait = v.dwait;
    bus0.p_BranchTaken = v.br; bus0.p_Exception = v.exc;
    bus1.p_ID_RS = v.id_rs; bus1.p_ID_RT = v.id_rt; bus1.p_ID_UsesRS = v.uses_rs; bus1.p_ID_UsesRT = v.uses_rt;
    bus1.p_IE_RS = v.ie_rs; bus1.p_IE_RT = v.ie_rt; bus1.p_IE_RegDest = v.ie_rd;
    bus1.p_MEM_RegDest = v.mem_rd; bus1.p_WB_RegDest = v.wb_rd;
    bus1.p_IE_RegWrite = v.ie_we; bus1.p_MEM_RegWrite = v.mem_we; bus1.p_WB_RegWrite = v.wb_we;
    bus1.p_IE_MemRead = v.ie_load; bus1.p_MEM_MemRead = v.mem_load;
    bus1.p_INST_MemWait = v.iwait; bus1.p_DATA_MemWait = v.dwait;
    bus1.p_BranchTaken = v.br; bus1.p_Exception = v.exc;
  endtask

  function automatic out_t act(input int k);
    if (k == 0) return mk_out(bus0.p_PC_Stall, bus0.p_Stall, bus0.p_Flush, bus0.p_FwdA, bus0.p_FwdB);
    return mk_out(bus1.p_PC_Stall, bus1.p_Stall, bus1.p_Flush, bus1.p_FwdA, bus1.p_FwdB);
  endfunction

  function automatic logic [63:0] act_sc(input int k);
    return (k == 0) ? {32'd0, bus0.p_StallCycles} : {32'd0, bus1.p_StallCycles};
  endfunction

  function automatic logic [63:0] act_fc(input int k);
    return (k == 0) ? {32'd0, bus0.p_FlushEvents} : {32'd0, bus1.p_FlushEvents};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d got=%0h exp=%0h t=%0t", nm, k, a, e, $time);
    end
  endtask

  task automatic chk_out(input string nm, input int k, input out_t e);
    out_t a = act(k);
    chk({nm, ".pc_stall"}, k, 64'(a.pc_stall), 64'(e.pc_stall));
    chk({nm, ".stall"},    k, 64'(a.stall),    64'(e.stall));
    chk({nm, ".flush"},    k, 64'(a.flush),    64'(e.flush));
    chk({nm, ".fwd_a"},    k, 64'(a.fwd_a),    64'(e.fwd_a));
    chk({nm, ".fwd_b"},    k, 64'(a.fwd_b),    64'(e.fwd_b));
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src, input in_t v);
    if (v.mem_we && !v.mem_load && v.mem_rd != 0 && v.mem_rd == src) return 2'b10;
    if (v.wb_we && v.wb_rd != 0 && v.wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  // Rule-level reference: pick the highest-priority event and apply its effect.
  task automatic model_eval(input in_t v, input int k, output out_t o,
                            output int nb, output bit np, output bit fl);
    bit lu = v.ie_load && v.ie_we && v.ie_rd != 0 &&
             ((v.uses_rs && v.id_rs == v.ie_rd) || (v.uses_rt && v.id_rt == v.ie_rd));
    o  = mk_out(0, 4'd0, 4'd0, fwd_of(v.ie_rs, v), fwd_of(v.ie_rt, v));
    nb = m_bub[k];
    np = m_pend[k];
    fl = 0;
    if (v.dwait) begin
      o.pc_stall = 1; o.stall = 4'b1111;
      if (v.exc) np = 1;
    end else if (v.exc || m_pend[k]) begin
      o.flush = 4'b0111; nb = 0; np = 0; fl = 1;
    end else if (v.br) begin
      o.flush = 4'((1 << bfd[k]) - 1); nb = 0; fl = 1;
    end else if (lu || m_bub[k] > 0) begin
      o.pc_stall = 1; o.stall = 4'b0001; o.flush = 4'b0010;
      nb = (m_bub[k] > 0) ? m_bub[k] - 1 : lub[k] - 1;
    end else if (v.iwait) begin
      o.pc_stall = 1; o.flush = 4'b0001;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input in_t v, input string nm);
    out_t e;
    int   nb[2];
    bit   np[2], fl[2], ps[2];
    drive(v);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_eval(v, k, e, nb[k], np[k], fl[k]);
      ps[k] = e.pc_stall;
      chk_out(nm, k, e);
      chk({nm, ".stall_cnt"}, k, act_sc(k), m_sc[k]);
      chk({nm, ".flush_cnt"}, k, act_fc(k), m_fc[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_bub[k]  = nb[k];
      m_pend[k] = np[k];
      if (ps[k] && m_sc[k] < CMAX) m_sc[k]++;
      if (fl[k] && m_fc[k] < CMAX) m_fc[k]++;
    end
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_pend[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk_out(nm, k, mk_out(0, 4'b0000, 4'b1111, 2'b00, 2'b00));
      chk({nm, ".stall_cnt"}, k, act_sc(k), 64'd0);
      chk({nm, ".flush_cnt"}, k, act_fc(k), 64'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle_in());
    rst_l = 1'b0;
    #1;
    chk_reset_vals("reset");
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t v;

    v = idle_in();                                 tbl.push_back(mk("run",       v, mk_out(0, 4'b0000, 4'b0000, 0, 0)));
    v = lu_in();                                   tbl.push_back(mk("lu_rs",     v, mk_out(1, 4'b0001, 4'b0010, 0, 0)));
    v = lu_in(); v.uses_rs = 0; v.uses_rt = 1; v.id_rt = 5; v.id_rs = 2;
                                                   tbl.push_back(mk("lu_rt",     v, mk_out(1, 4'b0001, 4'b0010, 0, 0)));
    v = lu_in(); v.ie_rd = 0; v.id_rs = 0;         tbl.push_back(mk("lu_r0",     v, mk_out(0, 4'b0000, 4'b0000, 0, 0)));
    v = lu_in(); v.uses_rs = 0;                    tbl.push_back(mk("lu_nouse",  v, mk_out(0, 4'b0000, 4'b0000, 0, 0)));
    v = lu_in(); v.ie_load = 0;                    tbl.push_back(mk("lu_noload", v, mk_out(0, 4'b0000, 4'b0000, 0, 0)));
    v = idle_in(); v.iwait = 1;                    tbl.push_back(mk("iwait",     v, mk_out(1, 4'b0000, 4'b0001, 0, 0)));
    v = idle_in(); v.dwait = 1;                    tbl.push_back(mk("dwait",     v, mk_out(1, 4'b1111, 4'b0000, 0, 0)));
    v = idle_in(); v.dwait = 1; v.iwait = 1;       tbl.push_back(mk("i_and_d",   v, mk_out(1, 4'b1111, 4'b0000, 0, 0)));
    v = idle_in(); v.br = 1;                       tbl.push_back(mk("branch",    v, mk_out(0, 4'b0000, 4'b0111, 0, 0)));
    v = idle_in(); v.exc = 1;                      tbl.push_back(mk("exc",       v, mk_out(0, 4'b0000, 4'b0111, 0, 0)));
    v = lu_in(); v.br = 1;                         tbl.push_back(mk("br_lu",     v, mk_out(0, 4'b0000, 4'b0111, 0, 0)));
    v = idle_in(); v.exc = 1; v.dwait = 1;         tbl.push_back(mk("exc_dw",    v, mk_out(1, 4'b1111, 4'b0000, 0, 0)));
    v = idle_in(); v.mem_we = 1; v.mem_rd = 7; v.wb_we = 1; v.wb_rd = 7; v.ie_rs = 7;
                                                   tbl.push_back(mk("fwd_mem",   v, mk_out(0, 4'b0000, 4'b0000, 2'b10, 0)));
    v.mem_load = 1;                                tbl.push_back(mk("fwd_wb",    v, mk_out(0, 4'b0000, 4'b0000, 2'b01, 0)));
    v.mem_load = 0; v.mem_rd = 0; v.wb_rd = 0; v.ie_rs = 0;
                                                   tbl.push_back(mk("fwd_r0",    v, mk_out(0, 4'b0000, 4'b0000, 2'b00, 0)));
    v = idle_in(); v.wb_we = 1; v.wb_rd = 9; v.ie_rt = 9; v.mem_we = 1; v.mem_rd = 4;
                                                   tbl.push_back(mk("fwd_b_wb",  v, mk_out(0, 4'b0000, 4'b0000, 0, 2'b01)));

    // Table: each vector from a fresh reset, constant expectations for dut0,
    // model expectations for both.
    foreach (tbl[i]) begin
      do_reset();
      drive(tbl[i].i);
      #1;
      chk_out({"tbl_", tbl[i].name}, 0, tbl[i].o);
      step(tbl[i].i, tbl[i].name);
    end

    // Load-use bubble count: 1 vs 2 cycles.
    do_reset();
    step(lu_in(), "lu_seq0");
    drive(idle_in()); #1;
    chk_out("lu_second", 0, mk_out(0, 4'b0000, 4'b0000, 0, 0));
    chk_out("lu_second", 1, mk_out(1, 4'b0001, 4'b0010, 0, 0));
    step(idle_in(), "lu_seq1");
    step(idle_in(), "lu_seq2");

    // Load-use held across a 3-cycle data wait.
    do_reset();
    v = lu_in(); v.dwait = 1;
    for (int n = 0; n < 3; n++) step(v, "lu_dw");
    step(lu_in(), "lu_dw_rel");
    step(idle_in(), "lu_dw_tail");
    chk("lu_dw_stallcnt", 0, act_sc(0), 64'd4);
    chk("lu_dw_stallcnt", 1, act_sc(1), 64'd5);

    // Exception pulse during a 2-cycle data wait.
    do_reset();
    v = idle_in(); v.dwait = 1; v.exc = 1;
    step(v, "exc_dw0");
    v.exc = 0;
    step(v, "exc_dw1");
    drive(idle_in()); #1;
    chk_out("exc_deferred", 0, mk_out(0, 4'b0000, 4'b0111, 0, 0));
    chk_out("exc_deferred", 1, mk_out(0, 4'b0000, 4'b0111, 0, 0));
    step(idle_in(), "exc_dw2");
    step(idle_in(), "exc_dw3");
    chk("exc_dw_flushcnt", 0, act_fc(0), 64'd1);
    chk("exc_dw_flushcnt", 1, act_fc(1), 64'd1);

    // Branch with load-use: flush wins, no leftover bubble.
    do_reset();
    v = lu_in(); v.br = 1;
    step(v, "br_lu0");
    drive(idle_in()); #1;
    chk_out("br_lu_after", 1, mk_out(0, 4'b0000, 4'b0000, 0, 0));
    step(idle_in(), "br_lu1");

    // Asynchronous reset mid-bubble.
    do_reset();
    step(lu_in(), "rst_bub0");
    drive(idle_in()); #1;
    chk_out("rst_bub_active", 1, mk_out(1, 4'b0001, 4'b0010, 0, 0));
    rst_l = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    model_clear();
    @(posedge clk);
    #2 rst_l = 1'b1;
    @(negedge clk);
    step(idle_in(), "rst_after");
    chk("rst_after_stallcnt", 1, act_sc(1), 64'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      v = idle_in();
      v.id_rs = 5'($urandom_range(0, 3)); v.id_rt = 5'($urandom_range(0, 3));
      v.ie_rs = 5'($urandom_range(0, 3)); v.ie_rt = 5'($urandom_range(0, 3));
      v.ie_rd = 5'($urandom_range(0, 3)); v.mem_rd = 5'($urandom_range(0, 3));
      v.wb_rd = 5'($urandom_range(0, 3));
      v.uses_rs = 1'($urandom_range(0, 1)); v.uses_rt = 1'($urandom_range(0, 1));
      v.ie_we = 1'($urandom_range(0, 1)); v.ie_load = 1'($urandom_range(0, 1));
      v.mem_we = 1'($urandom_range(0, 1)); v.mem_load = 1'($urandom_range(0, 1));
      v.wb_we = 1'($urandom_range(0, 1));
      v.iwait = ($urandom_range(0, 4) == 0);
      v.dwait = ($urandom_range(0, 4) == 0);
      v.br    = ($urandom_range(0, 5) == 0);
      v.exc   = ($urandom_range(0, 9) == 0);
      step(v, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips64_hazard_ctrl.md
# mips64_hazard_ctrl

Parametrised pipeline hazard and stall/flush controller for the 5-stage MIPS64 core; drives the stall and flush inputs of the IF/ID, ID/IE, IE/MEM and MEM/WB pipeline registers and the PC hold, which the first-generation core ties to zero. Handles instruction- and data-memory waits, load-use interlock with configurable bubble count, taken-branch and exception flushes with deferral across memory waits, and IE-stage operand forwarding. Also carries saturating stall and flush performance counters.

## Interface
- REG_AW, 5: register-address width.
- CNT_W, 32: performance counter width.
- LOAD_USE_BUBBLES, 1: bubbles inserted on a load-use hazard; legal values 1 or 2.
- BRANCH_FLUSH_DEPTH, 3: number of pipeline registers flushed on a taken branch, counted from IF/ID; legal range 1..3.

- p_clk  in  1  core clock, rising edge.
- p_rst_l  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- p_ID_RS, p_ID_RT  in  REG_AW  source registers of the instruction in ID.
- p_ID_UsesRS, p_ID_UsesRT  in  1  the ID instruction reads RS / RT.
- p_IE_RS, p_IE_RT  in  REG_AW  source registers of the instruction in IE.
- p_IE_RegDest, p_MEM_RegDest, p_WB_RegDest  in  REG_AW  destination register per stage.
- p_IE_RegWrite, p_MEM_RegWrite, p_WB_RegWrite  in  1  register-write enable per stage.
- p_IE_MemRead, p_MEM_MemRead  in  1  the stage holds a load.
- p_INST_MemWait, p_DATA_MemWait  in  1  memory wait strobes.
- p_BranchTaken  in  1  taken branch resolved in MEM; level signal, held while the branch sits in MEM.
- p_Exception  in  1  single-cycle exception pulse.
- p_PC_Stall  out  1  hold the PC.
- p_Stall  out  4  per-register hold; bit 0 is IF/ID, bit 3 is MEM/WB.
- p_Flush  out  4  per-register bubble insert, same bit order.
- p_FwdA, p_FwdB  out  2  IE operand select: 00 register file, 01 WB, 10 MEM.
- p_StallCycles, p_FlushEvents  out  CNT_W  saturating counters.

## Operation
- Registered state: bubble counter, exception-pending flag, two counters.
- Load-use hazard:
  - Condition: p_IE_MemRead & p_IE_RegWrite & p_IE_RegDest != 0 & (UsesRS & RS match, or UsesRT & RT match).
  - On detection: p_PC_Stall = 1, p_Stall[0] = 1, p_Flush[1] = 1.
  - With LOAD_USE_BUBBLES = 2, the bubble counter loads 1 and holds the same outputs for one extra cycle, independent of the inputs.
- Instruction wait: p_PC_Stall = 1, p_Flush[0] = 1. Downstream stages continue.
- Data wait: p_PC_Stall = 1 and p_Stall = 4'b1111. No flushes. The bubble counter freezes.
- Taken branch: p_Flush[BRANCH_FLUSH_DEPTH-1:0] = 1 with PC not stalled. Clears the bubble counter.
- Exception:
  - Effect: p_Flush[2:0] = 1. Clears the bubble counter.
  - If it arrives during a data wait, the pending flag sets; the flush applies in the first cycle the wait is low, and the flag then clears.
- Priority, highest first: data wait, exception or pending exception, taken branch, load-use (new or counter active), instruction wait, run.
- Forwarding, per operand:
  - Select 10 when MEM_RegWrite & !MEM_MemRead & MEM_RegDest != 0 & MEM_RegDest equals the IE source.
  - Otherwise select 01 on the equivalent WB match.
  - Otherwise select 00.
  - MEM has precedence over WB.
- Counters:
  - p_StallCycles increments every cycle p_PC_Stall = 1.
  - p_FlushEvents increments once per applied branch or exception flush cycle.
  - Both saturate at all-ones.

## Timing
- All stall, flush and forward outputs are combinational from the current inputs and registered state, valid in the same cycle. State and counters update on the rising edge.
- While p_rst_l = 0:
  - p_Flush = 4'b1111, p_Stall = 0, p_PC_Stall = 0, p_Fwd* = 00.
  - Counters, bubble counter and pending flag are 0.
- Reset asserted mid-bubble or while an exception is pending discards that state immediately.
- A branch that coincides with a data wait needs no latch, because the branch stays in MEM. It applies on the first cycle the wait is low.
- Instruction and data wait together: data-wait behaviour only.

## Structure
- Package mips64_pipe_pkg holds:
  - stage index constants: STG_IF_ID = 0 … STG_MEM_WB = 3;
  - forward encodings FWD_RF, FWD_WB, FWD_MEM;
  - the priority-cause enum used for debug visibility.
- Sub-module mips64_fwd_sel is combinational and instantiated once per operand.

## Test plan
- Load in IE with p_IE_RegDest = 5, ID reads RS = 5 → one cycle of PC_Stall = 1, Stall = 0001, Flush = 0010. With LOAD_USE_BUBBLES = 2, two cycles.
- Same load-use with p_DATA_MemWait high for 3 cycles → Stall = 1111 for 3 cycles, then the bubble completes. p_StallCycles advances by 4 (or 5 with LOAD_USE_BUBBLES = 2).
- p_Exception pulse during a 2-cycle data wait → Flush = 0111 only on the first cycle after the wait drops. p_FlushEvents = 1.
- BranchTaken together with a load-use hazard, BRANCH_FLUSH_DEPTH = 3 → Flush = 0111, PC_Stall = 0, bubble counter 0 next cycle.
- MEM and WB both write register 7 and IE_RS = 7 → FwdA = 10. With MEM_MemRead = 1 instead → FwdA = 01. With register 0 → 00.
- p_rst_l dropped mid-bubble → outputs go to reset values asynchronously; after release, Stall = 0 and both counters read 0.
